irq_priority_arbiter: RTL and testbench
=======================================

IRQ_PRIORITY_ARBITER -- requirements
Module: irq_priority_arbiter

Interface
REQ-001 Reset is synchronous and active-low; the block SHALL use a single clock.
REQ-002 pclk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous active-low reset, sampled on pclk rising edge.
REQ-004 psel  in  1  APB select.
REQ-005 penable  in  1  APB access phase.
REQ-006 pwrite  in  1  APB direction, 1 = write.
REQ-007 paddr  in  32  APB word index; only 0..3 decoded.
REQ-008 pwdata  in  32  APB write data.
REQ-009 prdata  out  32  APB read data.
REQ-010 pready  out  1  tied 1, zero wait states.
REQ-011 irq_trigger  in  4  per-source interrupt request, level sampled each edge.
REQ-012 irq_ack  in  1  CPU acknowledge of the presented interrupt.
REQ-013 irq_o  out  1  interrupt request to CPU.
REQ-014 irq_id_o  out  2  index of the presented or in-service source.

Function
REQ-015 Register map SHALL be: 0 PRIO RW [7:0], 2 bits per source, source i at [2i+1:2i], 3 = highest; 1 STATUS RO, [3:0] pending, [7:4] in-service one-hot; 2 EOI WO, bit mask; 3 ENABLE RW [3:0].
REQ-016 A write SHALL take effect on the edge where psel=1, penable=1, pwrite=1; writes to addr 1, and to any paddr >3, SHALL be ignored.
REQ-017 prdata SHALL be combinational: register value when psel=1 and pwrite=0 and paddr<=3 (unused bits 0), else 0; reads of addr 2 return 0.
REQ-018 pending[i] SHALL set on any edge where irq_trigger[i]=1, regardless of ENABLE, and stay set until acknowledged.
REQ-019 Eligible set = pending & ENABLE; winner = eligible source with largest PRIO field; ties go to lowest index.
REQ-020 FSM states IDLE, REQ, SERVICE; reset state IDLE.
REQ-021 IDLE: if eligible nonzero, latch winner into irq_id_o and go REQ; else stay.
REQ-022 REQ: irq_o=1, irq_id_o held stable; winner is not re-evaluated while in REQ.
REQ-023 REQ with irq_ack=1: clear pending[irq_id_o], set in-service bit, go SERVICE.
REQ-024 REQ with ENABLE[irq_id_o] cleared, ack not present: return to IDLE, pending retained; if ack and disable coincide, ack wins.
REQ-025 SERVICE: irq_o=0; leave to IDLE only on an EOI write with pwdata[irq_id_o]=1; in-service cleared same edge; other EOI bits ignored.
REQ-026 irq_ack outside REQ SHALL be ignored; EOI outside SERVICE SHALL be ignored.
REQ-027 Same-edge trigger on a source being acknowledged: set wins, pending[i] remains 1.
REQ-028 Latency: trigger sampled at edge k -> pending after k -> irq_o=1 after edge k+1 (source enabled, FSM idle).
REQ-029 No preemption: higher-priority arrivals wait until SERVICE exits; next arbitration on first IDLE cycle.
REQ-030 At most one in-service bit set at any time.

Reset
REQ-031 On rst_n=0 at an edge: PRIO=0, ENABLE=0, pending=0, in-service=0, FSM=IDLE, irq_o=0, irq_id_o=0.
REQ-032 Reset SHALL override any simultaneous APB write, trigger or ack, including mid-REQ or mid-SERVICE.
REQ-033 prdata and pready follow REQ-010/REQ-017 during reset.

Verification
REQ-034 Write ENABLE=4'b0011, pulse trigger 4'b0010 one cycle -> irq_o=1 two edges after pulse, irq_id_o=1, STATUS reads 0x02.
REQ-035 In REQ assert irq_ack one cycle -> irq_o=0, STATUS 0x20; write EOI=4'b0010 -> STATUS 0x00, FSM IDLE.
REQ-036 PRIO=0x0C (src1=3), ENABLE=0xF, trigger 4'b0011 same cycle -> irq_id_o=1 first; after ack+EOI, irq_id_o=0 presented next.
REQ-037 ENABLE=0, trigger 4'b0100 -> no irq_o, STATUS 0x04; then ENABLE=0x4 -> irq_o=1, irq_id_o=2.
REQ-038 In REQ for src0 clear ENABLE -> irq_o=0 next edge, STATUS keeps 0x01; ack while in IDLE has no effect.
REQ-039 rst_n=0 for one edge during SERVICE -> all outputs and registers at REQ-031 values, STATUS reads 0.

Source files
------------

// File: rtl/irq_priority_arbiter_if.sv
// APB slave bus bundle for the interrupt priority arbiter.
//   psel, penable, pwrite : APB select / access phase / direction (1 = write)
//   paddr                 : word index, only 0..3 are decoded by the slave
//   pwdata                : write data
//   prdata                : combinational read data from the slave
//   pready                : always 1, zero wait states
interface irq_priority_arbiter_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/irq_priority_arbiter.sv
// Four-source interrupt priority arbiter with an APB register file.
// Pending requests are latched from level triggers; the highest-priority
// enabled pending source is presented to the CPU, acknowledged, and held
// in service until software writes the matching EOI bit.
//
// Ports:
//   pclk        : sole clock, rising edge
//   rst_n       : synchronous active-low reset
//   apb         : APB slave (psel/penable/pwrite/paddr/pwdata/prdata/pready)
//   irq_trigger : per-source request level, sampled every edge
//   irq_ack     : CPU acknowledge of the presented interrupt
//   irq_o       : interrupt request to the CPU
//   irq_id_o    : index of the presented or in-service source
//
// Register map (word index):
//   0 PRIO   RW [7:0] two bits per source, 3 = highest
//   1 STATUS RO [3:0] pending, [7:4] in-service one-hot
//   2 EOI    WO bit mask, only the bit of the in-service source matters
//   3 ENABLE RW [3:0]
module irq_priority_arbiter (
    input  logic                   pclk,
    input  logic                   rst_n,
    irq_priority_arbiter_if.slave  apb,
    input  logic [3:0]             irq_trigger,
    input  logic                   irq_ack,
    output logic                   irq_o,
    output logic [1:0]             irq_id_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  prio_q;
    logic [3:0]  enable_q;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  insvc_q, insvc_d;
    logic [1:0]  id_d;
    logic [3:0]  ack_clr;

    logic        wr_en, addr_ok;
    logic        wr_prio, wr_enable, wr_eoi;
    logic [3:0]  eligible;
    logic [1:0]  win_id;
    logic [1:0]  win_prio;
    logic        win_found;
    logic        unused_pwdata;

    assign wr_en     = apb.psel & apb.penable & apb.pwrite;
    assign addr_ok   = (apb.paddr[31:2] == 30'd0);
    assign wr_prio   = wr_en && (apb.paddr == 32'd0);
    assign wr_eoi    = wr_en && (apb.paddr == 32'd2);
    assign wr_enable = wr_en && (apb.paddr == 32'd3);

    assign unused_pwdata = ^apb.pwdata[31:8];

    assign eligible = pending_q & enable_q;

    // Scan upward with a strict greater-than so equal priorities keep the
    // lowest index.
    always_comb begin
        win_id    = 2'd0;
        win_prio  = 2'd0;
        win_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (eligible[i] && (!win_found || (prio_q[2*i +: 2] > win_prio))) begin
                win_found = 1'b1;
                win_id    = 2'(i);
                win_prio  = prio_q[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = irq_id_o;
        insvc_d = insvc_q;
        ack_clr = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    id_d    = win_id;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack takes precedence over a coincident disable.
                if (irq_ack) begin
                    ack_clr = 4'b0001 << irq_id_o;
                    insvc_d = 4'b0001 << irq_id_o;
                    state_d = ST_SERVICE;
                end else if (!enable_q[irq_id_o]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi && apb.pwdata[irq_id_o]) begin
                    insvc_d = 4'b0000;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A trigger on the same edge as its ack re-arms the source.
        pending_d = (pending_q & ~ack_clr) | irq_trigger;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            prio_q    <= 8'd0;
            enable_q  <= 4'd0;
            pending_q <= 4'd0;
            insvc_q   <= 4'd0;
            irq_id_o  <= 2'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            insvc_q   <= insvc_d;
            irq_id_o  <= id_d;
            if (wr_prio) begin
                prio_q <= apb.pwdata[7:0];
            end
            if (wr_enable) begin
                enable_q <= apb.pwdata[3:0];
            end
        end
    end

    assign irq_o      = (state_q == ST_REQ);
    assign apb.pready = 1'b1;

    always_comb begin
        apb.prdata = 32'd0;
        if (apb.psel && !apb.pwrite && addr_ok) begin
            case (apb.paddr[1:0])
                2'd0:    apb.prdata[7:0] = prio_q;
                2'd1:    apb.prdata[7:0] = {insvc_q, pending_q};
                2'd3:    apb.prdata[3:0] = enable_q;
                default: apb.prdata      = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Bench for irq_priority_arbiter: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a transaction-level model of the arbiter.
module tb_irq_priority_arbiter;

    logic       pclk;
    logic       rst_n;
    logic [3:0] irq_trigger;
    logic       irq_ack;
    logic       irq_o;
    logic [1:0] irq_id_o;

    irq_priority_arbiter_if bus ();

    irq_priority_arbiter dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .apb         (bus),
        .irq_trigger (irq_trigger),
        .irq_ack     (irq_ack),
        .irq_o       (irq_o),
        .irq_id_o    (irq_id_o)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_prio;
    logic [3:0] m_en, m_pend, m_ins;
    bit         m_presenting, m_serving;
    logic [1:0] m_id;

    // Highest priority level first, lowest index within a level.
    function automatic int best_src(input logic [3:0] elig, input logic [7:0] pr);
        for (int p = 3; p >= 0; p--)
            for (int i = 0; i < 4; i++)
                if (elig[i] && (int'(pr[2*i +: 2]) == p)) return i;
        return -1;
    endfunction

    initial begin
        m_prio = 0; m_en = 0; m_pend = 0; m_ins = 0;
        m_presenting = 0; m_serving = 0; m_id = 0;
    end

    always @(posedge pclk) begin
        logic       wr;
        logic [3:0] n_pend;
        int         b;
        if (!rst_n) begin
            m_prio = 0; m_en = 0; m_pend = 0; m_ins = 0;
            m_presenting = 0; m_serving = 0; m_id = 0;
        end else begin
            wr = bus.psel && bus.penable && bus.pwrite;
            n_pend = m_pend;
            if (m_presenting) begin
                if (irq_ack) begin
                    n_pend[m_id] = 1'b0;
                    m_ins = 4'b0;
                    m_ins[m_id] = 1'b1;
                    m_presenting = 0;
                    m_serving = 1;
                end else if (!m_en[m_id]) begin
                    m_presenting = 0;
                end
            end else if (m_serving) begin
                if (wr && bus.paddr == 32'd2 && bus.pwdata[m_id]) begin
                    m_ins = 0;
                    m_serving = 0;
                end
            end else begin
                b = best_src(m_pend & m_en, m_prio);
                if (b >= 0) begin
                    m_id = 2'(b);
                    m_presenting = 1;
                end
            end
            m_pend = n_pend | irq_trigger;
            if (wr && bus.paddr == 32'd0) m_prio = bus.pwdata[7:0];
            if (wr && bus.paddr == 32'd3) m_en = bus.pwdata[3:0];
        end
    end

    function automatic logic [31:0] exp_rd();
        if (!bus.psel || bus.pwrite || bus.paddr > 32'd3) return 32'd0;
        case (bus.paddr)
            32'd0:   return {24'd0, m_prio};
            32'd1:   return {24'd0, m_ins, m_pend};
            32'd3:   return {28'd0, m_en};
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge pclk) begin
        if (chk_on) begin
            check("irq_o",    32'(irq_o),      32'(m_presenting));
            check("irq_id_o", 32'(irq_id_o),   32'(m_id));
            check("pready",   32'(bus.pready), 32'd1);
            check("prdata",   bus.prdata,      exp_rd());
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle_bus();
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
        bus.paddr = 0; bus.pwdata = 0;
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        bus.psel = 1; bus.penable = 1; bus.pwrite = 1;
        bus.paddr = a; bus.pwdata = d;
        tick();
        idle_bus();
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.psel = 1; bus.penable = 0; bus.pwrite = 0; bus.paddr = a;
        #1;
        check(name, bus.prdata, exp);
        idle_bus();
    endtask

    task automatic pulse_trig(input logic [3:0] t);
        irq_trigger = t;
        tick();
        irq_trigger = 0;
    endtask

    task automatic do_ack();
        irq_ack = 1;
        tick();
        irq_ack = 0;
    endtask

    initial begin
        rst_n = 0; irq_trigger = 0; irq_ack = 0;
        idle_bus();
        tick();
        chk_on = 1;
        tick();
        check("rst_irq_o", 32'(irq_o), 32'd0);
        check("rst_id", 32'(irq_id_o), 32'd0);
        rd_chk("rst_status", 1, 32'h00);
        rd_chk("rst_prio", 0, 32'h00);
        rd_chk("rst_enable", 3, 32'h0);
        rst_n = 1;
        tick();

        // Basic present / ack / EOI
        apb_wr(3, 32'h3);
        pulse_trig(4'b0010);
        check("lat_not_yet", 32'(irq_o), 32'd0);
        tick();
        check("lat_irq_o", 32'(irq_o), 32'd1);
        check("lat_id", 32'(irq_id_o), 32'd1);
        rd_chk("lat_status", 1, 32'h02);
        rd_chk("eoi_reads_zero", 2, 32'h0);
        do_ack();
        check("ack_irq_o", 32'(irq_o), 32'd0);
        rd_chk("ack_status", 1, 32'h20);
        apb_wr(2, 32'h2);
        rd_chk("eoi_status", 1, 32'h00);
        tick();
        check("eoi_idle", 32'(irq_o), 32'd0);

        // Priority ordering, no preemption
        apb_wr(0, 32'h0C);
        apb_wr(3, 32'hF);
        pulse_trig(4'b0011);
        tick();
        check("prio_first", 32'(irq_id_o), 32'd1);
        do_ack();
        apb_wr(2, 32'h2);
        tick();
        check("prio_second_irq", 32'(irq_o), 32'd1);
        check("prio_second_id", 32'(irq_id_o), 32'd0);
        do_ack();
        apb_wr(2, 32'h1);

        // Equal priority: lowest index first
        apb_wr(0, 32'h00);
        pulse_trig(4'b1100);
        tick();
        check("tie_id", 32'(irq_id_o), 32'd2);
        do_ack();
        apb_wr(2, 32'hF);
        tick();
        check("tie_next_id", 32'(irq_id_o), 32'd3);
        do_ack();
        apb_wr(2, 32'h8);

        // Pending while disabled, released by enable
        apb_wr(3, 32'h0);
        pulse_trig(4'b0100);
        tick();
        check("dis_irq_o", 32'(irq_o), 32'd0);
        rd_chk("dis_status", 1, 32'h04);
        apb_wr(3, 32'h4);
        tick();
        check("en_irq_o", 32'(irq_o), 32'd1);
        check("en_id", 32'(irq_id_o), 32'd2);
        do_ack();
        apb_wr(2, 32'h4);

        // Disable while presenting withdraws the request
        apb_wr(3, 32'h1);
        pulse_trig(4'b0001);
        tick();
        check("wd_req", 32'(irq_o), 32'd1);
        apb_wr(3, 32'h0);
        tick();
        check("wd_irq_o", 32'(irq_o), 32'd0);
        rd_chk("wd_status", 1, 32'h01);
        do_ack();
        check("stray_ack", 32'(irq_o), 32'd0);
        rd_chk("stray_ack_status", 1, 32'h01);
        apb_wr(2, 32'hF);
        rd_chk("stray_eoi_status", 1, 32'h01);

        // Ack with same-edge retrigger, then reset mid-SERVICE
        apb_wr(3, 32'h1);
        tick();
        check("re_req", 32'(irq_o), 32'd1);
        irq_trigger = 4'b0001;
        do_ack();
        irq_trigger = 0;
        rd_chk("retrig_status", 1, 32'h11);
        rst_n = 0; irq_trigger = 4'hF; irq_ack = 1;
        bus.psel = 1; bus.penable = 1; bus.pwrite = 1;
        bus.paddr = 0; bus.pwdata = 32'hFF;
        tick();
        rst_n = 1; irq_trigger = 0; irq_ack = 0;
        idle_bus();
        check("mid_rst_irq_o", 32'(irq_o), 32'd0);
        check("mid_rst_id", 32'(irq_id_o), 32'd0);
        rd_chk("mid_rst_status", 1, 32'h00);
        rd_chk("mid_rst_prio", 0, 32'h00);
        rd_chk("mid_rst_enable", 3, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            bus.psel    = 1'($urandom_range(0, 1));
            bus.penable = ($urandom_range(0, 3) != 0);
            bus.pwrite  = 1'($urandom_range(0, 1));
            bus.paddr   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4));
            bus.pwdata  = $urandom;
            irq_trigger = 4'($urandom) & 4'($urandom) & 4'($urandom);
            irq_ack     = ($urandom_range(0, 2) == 0);
            tick();
        end
        rst_n = 1; irq_trigger = 0; irq_ack = 0;
        idle_bus();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
